uart_rx_marco: RTL



---
 rtl/uart_rx_marco_pkg.sv | 32 +++
 rtl/uart_cmd_match.sv | 50 +++++
 rtl/uart_rx_marco.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/uart_rx_marco_pkg.sv
// Shared definitions for the MARCO command receiver: deframer states, command bytes and defaults.
package uart_rx_marco_pkg;

  localparam int unsigned OversampleDef = 16;
  localparam int unsigned MsgLen        = 5;

  localparam logic [7:0] ChM = 8'h4D;
  localparam logic [7:0] ChA = 8'h41;
  localparam logic [7:0] ChR = 8'h52;
  localparam logic [7:0] ChC = 8'h43;
  localparam logic [7:0] ChO = 8'h4F;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd3,
    StBreak = 3'd4
  } rx_state_e;

  function automatic logic [7:0] marco_char(input logic [2:0] idx);
    case (idx)
      3'd0:    marco_char = ChM;
      3'd1:    marco_char = ChA;
      3'd2:    marco_char = ChR;
      3'd3:    marco_char = ChC;
      3'd4:    marco_char = ChO;
      default: marco_char = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_match.sv
// Byte-stream matcher: pulses hit_o one clock after the last byte of "MARCO" is accepted.
module uart_cmd_match
  import uart_rx_marco_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_i,
  input  logic       byte_valid_i,
  input  logic       clr_i,
  output logic       hit_o
);

  localparam logic [2:0] LastIdx = 3'(MsgLen - 1);

  logic [2:0] idx_q, idx_d;
  logic       hit_q, hit_d;

  always_comb begin
    idx_d = idx_q;
    hit_d = 1'b0;
    if (clr_i) begin
      idx_d = '0;
    end else if (byte_valid_i) begin
      if (byte_i == marco_char(idx_q)) begin
        if (idx_q == LastIdx) begin
          hit_d = 1'b1;
          idx_d = '0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end else begin
        // Only an 'M' can start a new attempt mid-sequence.
        idx_d = (byte_i == ChM) ? 3'd1 : 3'd0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      hit_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      hit_q <= hit_d;
    end
  end

  assign hit_o = hit_q;

endmodule

// File: rtl/uart_rx_marco.sv
// 8N1 UART receiver with 16x oversampling; feeds received bytes to the MARCO matcher.
module uart_rx_marco
  import uart_rx_marco_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = OversampleDef
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       os_tick_i,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       frame_err_o,
  output logic       busy_o,
  output logic       marco_hit_o
);

  localparam int unsigned      TickW    = $clog2(OVERSAMPLE);
  localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);

  logic             rx_meta_q, rx_s_q;
  rx_state_e        state_q, state_d;
  logic [TickW-1:0] tick_q, tick_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    if (os_tick_i) begin
      case (state_q)
        StIdle: begin
          if (!rx_s_q) begin
            state_d = StStart;
            tick_d  = '0;
          end
        end
        StStart: begin
          tick_d = tick_q + 1'b1;
          if (tick_q == TickMid) begin
            if (rx_s_q) begin
              state_d = StIdle;
            end else begin
              tick_d  = '0;
              bit_d   = '0;
              state_d = StData;
            end
          end
        end
        StData: begin
          tick_d = tick_q + 1'b1;
          if (tick_q == TickLast) begin
            shift_d = {rx_s_q, shift_q[7:1]};
            tick_d  = '0;
            if (bit_q == 3'd7) begin
              state_d = StStop;
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
        StStop: begin
          tick_d = tick_q + 1'b1;
          if (tick_q == TickLast) begin
            tick_d = '0;
            if (rx_s_q) begin
              data_d  = shift_q;
              valid_d = 1'b1;
              state_d = StIdle;
            end else begin
              ferr_d  = 1'b1;
              state_d = StBreak;
            end
          end
        end
        StBreak: begin
          // Held-low line: wait for idle without repeating the error.
          if (rx_s_q) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          tick_d  = '0;
          bit_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_data_o   = data_q;
  assign rx_valid_o  = valid_q;
  assign frame_err_o = ferr_q;
  assign busy_o      = (state_q != StIdle);

  uart_cmd_match u_cmd_match (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_i       (data_q),
    .byte_valid_i (valid_q),
    .clr_i        (ferr_q),
    .hit_o        (marco_hit_o)
  );

endmodule
